// File: rtl/flm_alloc_if.sv
// Allocation / free handshake bundle for flm_alloc.
// master = ID consumer/retire side, slave = the free-list manager.
interface flm_alloc_if #(
  parameter int N   = 16,
  parameter int F_N = 2
);
  localparam int W = $clog2(N);

  logic               alloc_req;
  logic               alloc_gnt;
  logic [W-1:0]       alloc_id;
  logic [F_N-1:0]     free_vld;
  logic [F_N*W-1:0]   free_id;
  logic               clear;

  modport master (output alloc_req, free_vld, free_id, clear,
                  input  alloc_gnt, alloc_id);
  modport slave  (input  alloc_req, free_vld, free_id, clear,
                  output alloc_gnt, alloc_id);
endinterface

// File: rtl/flm_alloc.sv
// Free-list manager: lowest-free-ID allocator with F_N free ports and clear.
// Optional FLM_ALLOC_ERR_CHECK_EN builds the sticky protocol-error flag.
module flm_alloc #(
  parameter  int N   = 16,
  parameter  int F_N = 2,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  flm_alloc_if.slave   bus,
  output logic [N-1:0] state_r,
  output logic [W:0]   cnt_r,
  output logic         idle_r,
  output logic         busy_r,
  output logic         err_r
);
  logic [W-1:0] low_id;
  logic [N-1:0] gnt_mask;
  logic [N-1:0] free_or;
  logic [N-1:0] state_w;
  logic [W:0]   cnt_w;

  // Priority encode from the top down so the last hit is the lowest free index.
  always_comb begin
    low_id = '0;
    for (int i = N-1; i >= 0; i--)
      if (!state_r[i]) low_id = W'(i);
  end

  assign bus.alloc_gnt = bus.alloc_req & ~busy_r & ~bus.clear & rst_n;
  assign bus.alloc_id  = busy_r ? '0 : low_id;

  // Out-of-range free IDs decode to nothing; duplicate frees collapse in the OR.
  always_comb begin
    free_or = '0;
    for (int p = 0; p < F_N; p++)
      if (bus.free_vld[p] && int'(bus.free_id[p*W +: W]) < N)
        free_or[bus.free_id[p*W +: W]] = 1'b1;
  end

  always_comb begin
    gnt_mask = '0;
    if (bus.alloc_gnt) gnt_mask[bus.alloc_id] = 1'b1;
    state_w = bus.clear ? '0 : ((state_r | gnt_mask) & ~free_or);
    cnt_w = '0;
    for (int i = 0; i < N; i++) cnt_w = cnt_w + (W+1)'(state_w[i]);
  end

  // Status is recomputed from the next vector each cycle, so it can never drift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= '0;
      cnt_r   <= '0;
      idle_r  <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_w;
      cnt_r   <= cnt_w;
      idle_r  <= (cnt_w == '0);
      busy_r  <= (cnt_w == (W+1)'(N));
    end
  end

`ifdef FLM_ALLOC_ERR_CHECK_EN
  logic err_w;

  always_comb begin
    err_w = 1'b0;
    for (int p = 0; p < F_N; p++) begin
      if (bus.free_vld[p]) begin
        if (int'(bus.free_id[p*W +: W]) >= N)        err_w = 1'b1;
        else if (!state_r[bus.free_id[p*W +: W]])    err_w = 1'b1;
        for (int q = p + 1; q < F_N; q++)
          if (bus.free_vld[q] && bus.free_id[q*W +: W] == bus.free_id[p*W +: W])
            err_w = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_r <= 1'b0;
    else if (bus.clear) err_r <= 1'b0;
    else                err_r <= err_r | err_w;
  end
`else
  assign err_r = 1'b0;
`endif

endmodule
